// File: rtl/exc_seq.sv
// ============================================================================
//  Module   : exc_seq
//  Brief    : Exception sequencer - saves PC-4 to EPC, fetches the handler
//             vector byte from memory and loads it into the PC.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module exc_seq #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_en,
    input  logic        exc_opcode,
    input  logic        exc_ovf,
    input  logic        exc_div0,
    input  logic [31:0] pc_in,
    input  logic [7:0]  mem_byte,
    output logic        busy,
    output logic        iord_own,
    output logic [2:0]  iord_sel,
    output logic        epc_write,
    output logic [31:0] epc_data,
    output logic        pc_write,
    output logic [31:0] pc_value,
    output logic [1:0]  exc_cause,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SAVE = 3'd1,
        S_ADDR = 3'd2,
        S_WAIT = 3'd3,
        S_LOAD = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // WAIT lasts MEM_LAT-1 cycles: counter loads MEM_LAT-2 and exits at zero
    localparam logic [1:0] c_WAIT_INIT = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_cause;
    logic [31:0] r_pc;
    logic [1:0]  r_wcnt;
    logic        w_capture;
    logic [1:0]  w_cause_new;
    logic [2:0]  w_sel;

    assign w_capture = (r_state == S_IDLE) && exc_en &&
                       (exc_opcode || exc_ovf || exc_div0);

    always_comb begin
        if (exc_opcode)   w_cause_new = 2'b01;
        else if (exc_ovf) w_cause_new = 2'b10;
        else              w_cause_new = 2'b11;
    end

    always_comb begin
        case (r_cause)
            2'b01:   w_sel = 3'b011;
            2'b10:   w_sel = 3'b100;
            default: w_sel = 3'b101;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cause <= 2'b00;
            r_pc    <= 32'd0;
            r_wcnt  <= 2'd0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_cause <= w_cause_new;
                r_pc    <= pc_in;
            end
            if (r_state == S_ADDR)
                r_wcnt <= c_WAIT_INIT;
            else if ((r_state == S_WAIT) && (r_wcnt != 2'd0))
                r_wcnt <= r_wcnt - 2'd1;
        end
    end

    always_comb begin
        w_next    = r_state;
        busy      = 1'b0;
        iord_own  = 1'b0;
        iord_sel  = 3'b000;
        epc_write = 1'b0;
        epc_data  = 32'd0;
        pc_write  = 1'b0;
        pc_value  = 32'd0;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_capture) w_next = S_SAVE;
            end
            S_SAVE: begin
                busy      = 1'b1;
                epc_write = 1'b1;
                epc_data  = r_pc - 32'd4;
                w_next    = S_ADDR;
            end
            S_ADDR: begin
                busy     = 1'b1;
                iord_own = 1'b1;
                iord_sel = w_sel;
                w_next   = (MEM_LAT > 1) ? S_WAIT : S_LOAD;
            end
            S_WAIT: begin
                busy     = 1'b1;
                iord_own = 1'b1;
                iord_sel = w_sel;
                if (r_wcnt == 2'd0) w_next = S_LOAD;
            end
            S_LOAD: begin
                busy     = 1'b1;
                iord_own = 1'b1;
                iord_sel = w_sel;
                pc_write = 1'b1;
                pc_value = {24'd0, mem_byte};
                w_next   = S_DONE;
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign exc_cause = r_cause;

endmodule

`default_nettype wire

// File: doc/exc_seq.md
EXC_SEQ -- requirements
Module: exc_seq

Interface
- REQ-001: Parameter MEM_LAT, default 2, memory read latency in cycles from address presented to byte valid; legal range 1..4.
- REQ-002: clk  input  1  single clock; all state changes on rising edge.
- REQ-003: reset  input  1  asynchronous, active-low reset.
- REQ-004: exc_en  input  1  main control is in an exception-sampling state.
- REQ-005: exc_opcode  input  1  invalid-opcode event.
- REQ-006: exc_ovf  input  1  arithmetic-overflow event.
- REQ-007: exc_div0  input  1  divide-by-zero event.
- REQ-008: pc_in  input  32  current PC value.
- REQ-009: mem_byte  input  8  low byte of memory read data.
- REQ-010: busy  output  1  sequencer owns the datapath; main control stalls.
- REQ-011: iord_own  output  1  sequencer overrides the memory-address selector.
- REQ-012: iord_sel  output  3  address-selector code while iord_own=1.
- REQ-013: epc_write  output  1  EPC register load strobe.
- REQ-014: epc_data  output  32  value loaded into EPC.
- REQ-015: pc_write  output  1  PC load strobe.
- REQ-016: pc_value  output  32  value loaded into PC.
- REQ-017: exc_cause  output  2  latched cause: 00 none, 01 opcode, 10 overflow, 11 div0.
- REQ-018: done  output  1  one-cycle completion pulse.

Function
- REQ-019: States IDLE, SAVE, ADDR, WAIT, LOAD, DONE; encoding free.
- REQ-020: In IDLE, a rising edge with exc_en=1 and any exception input=1 SHALL capture cause and pc_in, then enter SAVE.
- REQ-021: Priority opcode > overflow > div0; lower-priority simultaneous events are discarded.
- REQ-022: Exception inputs SHALL be ignored when exc_en=0 or when not IDLE; no queuing, no nesting.
- REQ-023: SAVE (1 cycle): epc_write=1, epc_data = captured PC - 4 (modulo 2^32, 0 -> FFFFFFFC).
- REQ-024: ADDR (1 cycle), WAIT (MEM_LAT-1 cycles, skipped when MEM_LAT=1), LOAD (1 cycle): iord_own=1, iord_sel = 011 (opcode), 100 (overflow), 101 (div0).
- REQ-025: LOAD: pc_write=1, pc_value = {24'b0, mem_byte} sampled combinationally that cycle.
- REQ-026: DONE (1 cycle): done=1, then IDLE.
- REQ-027: busy=1 in every state except IDLE; total busy length = MEM_LAT+3 cycles.
- REQ-028: Outside their stated states iord_own, epc_write, pc_write, done SHALL be 0, iord_sel 000, epc_data and pc_value 0.
- REQ-029: WAIT counter SHALL count MEM_LAT-1 cycles exactly, reloading on each entry.
- REQ-030: exc_cause SHALL update only on capture and hold through IDLE until the next capture.
- REQ-031: A new exception in the DONE cycle is ignored; one asserted in the first IDLE cycle after DONE is accepted.

Reset
- REQ-032: reset=0 SHALL immediately force IDLE, all outputs 0, exc_cause 00, WAIT counter 0, independent of clk.
- REQ-033: Reset mid-sequence SHALL abort without any further epc_write or pc_write pulse; first capture possible on the first edge after reset deasserts.

Verification
- REQ-034: MEM_LAT=2, pc_in=0x00000040, exc_ovf=1, exc_en=1 -> SAVE epc_data=0x3C; iord_sel=100 for 3 cycles; LOAD with mem_byte=0x9A gives pc_value=0x9A; done 5 cycles after capture; exc_cause=10.
- REQ-035: all three events at once -> iord_sel=011, exc_cause=01, one sequence only.
- REQ-036: exc_en=0 with exc_div0=1 -> busy stays 0; then exc_en=1 during busy -> ignored, no second sequence.
- REQ-037: MEM_LAT=1, exc_div0, pc_in=0 -> epc_data=0xFFFFFFFC, no WAIT state, busy 4 cycles.
- REQ-038: reset low during WAIT -> busy, iord_own, pc_write drop at once; no pc_write pulse follows; exc_cause=00.
- REQ-039: exc_opcode asserted in DONE cycle and held into next cycle -> second sequence starts from the following IDLE edge.
